// File: rtl/image_rle_decompressor_if.sv
// Bus bundle for the RLE decompressor: compressed-word input handshake,
// image-buffer write port and status flags.
//
// Handshake: a compressed word moves from master to slave on a rising edge
// where in_valid && in_ready && !clear. in_valid may be held across cycles.
// Din only needs to be stable in the cycle the transfer happens. in_ready
// never depends on in_valid. clear wins over a simultaneous in_valid.
interface image_rle_decompressor_if #(
    parameter int ADDR_W = 6
);
    logic              clear;
    logic              in_valid;
    logic [15:0]       Din;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              done;
    logic              overflow;

    // Coordinator side: supplies words and restarts, observes results
    modport master (
        output clear, in_valid, Din,
        input  in_ready, wr_en, wr_addr, wr_data, done, overflow
    );

    // Decompressor side
    modport slave (
        input  clear, in_valid, Din,
        output in_ready, wr_en, wr_addr, wr_data, done, overflow
    );
endinterface

// File: rtl/image_rle_decompressor.sv
// Run-length decompressor. Each 16-bit input word carries two codes
// {value, length[6:0]}; runs expand to one binary pixel per cycle.
// Pixels are packed LSB-first into 16-bit words for the image buffer.
// The last partial word is flushed, and done is raised once every
// write has gone out.
module image_rle_decompressor #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 6
) (
    input  logic                           clk,
    input  logic                           RST,
    image_rle_decompressor_if.slave        bus,
    output logic [2:0]                     fsm_state
);

    localparam int PIX_W = $clog2(NUM_PIXELS + 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);
    // A partial final word exists only when the image is not a multiple of 16
    localparam bit HAS_TAIL = (NUM_PIXELS % 16) != 0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN1  = 3'd1;
    localparam logic [2:0] S_RUN2  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic              alive;      // low while in reset, so in_ready stays low
    logic              run_val;    // pixel value of the run being expanded
    logic [6:0]        run_rem;    // pixels still to emit in the current run
    logic [7:0]        code2;      // second code, held until RUN1 finishes
    logic [PIX_W-1:0]  pix_cnt;
    logic [15:0]       pack;
    logic [ADDR_W-1:0] word_idx;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [15:0]       wr_data_q;
    logic              done_q;
    logic              overflow_q;

    logic              in_run;
    logic              emit;
    logic [3:0]        bit_pos;
    logic [15:0]       pack_set;
    logic              word_full;
    logic              last_pix;
    logic              run_end;
    logic              surplus;
    logic              accept;

    // Per-cycle decode: does this cycle emit a pixel, and what does it complete
    always_comb begin
        in_run    = (state == S_RUN1) || (state == S_RUN2);
        emit      = in_run && (run_rem != 7'd0);
        bit_pos   = pix_cnt[3:0];
        pack_set  = pack;
        pack_set[bit_pos] = run_val;
        word_full = emit && (bit_pos == 4'd15);
        last_pix  = emit && (pix_cnt == LAST_PIX);
        // A zero-length run also ends here, after its single idle cycle
        run_end   = in_run && (run_rem <= 7'd1);
        // Pixels left over once the image is full: rest of this run, or an
        // unstarted nonzero second run
        surplus   = (run_rem > 7'd1) ||
                    ((state == S_RUN1) && (code2[6:0] != 7'd0));
        accept    = (state == S_IDLE) && alive && bus.in_valid && !bus.clear;
    end

    // Ready gate: held low through reset, high from the first edge after it
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
        end
    end

    // Control FSM: accept, expand the two runs, flush, then park in DONE
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            run_val <= 1'b0;
            run_rem <= 7'd0;
            code2   <= 8'd0;
        end else if (bus.clear) begin
            state   <= S_IDLE;
            run_val <= 1'b0;
            run_rem <= 7'd0;
            code2   <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        run_val <= bus.Din[15];
                        run_rem <= bus.Din[14:8];
                        code2   <= bus.Din[7:0];
                        state   <= S_RUN1;
                    end
                end
                S_RUN1, S_RUN2: begin
                    if (last_pix) begin
                        state <= HAS_TAIL ? S_FLUSH : S_DONE;
                    end else if (run_end) begin
                        if (state == S_RUN1) begin
                            run_val <= code2[7];
                            run_rem <= code2[6:0];
                            state   <= S_RUN2;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        run_rem <= run_rem - 7'd1;
                    end
                end
                S_FLUSH: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Pixel packing: place each emitted pixel, hand full words to the writer
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pix_cnt <= '0;
            pack    <= 16'd0;
        end else if (bus.clear) begin
            pix_cnt <= '0;
            pack    <= 16'd0;
        end else if (emit) begin
            pix_cnt <= pix_cnt + PIX_W'(1);
            // Clearing on word completion keeps unfilled bits zero for the flush
            pack    <= word_full ? 16'd0 : pack_set;
        end else if (state == S_FLUSH) begin
            pack    <= 16'd0;
        end
    end

    // Registered write port: one strobe per completed or flushed word
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 16'd0;
            word_idx  <= '0;
        end else if (bus.clear) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 16'd0;
            word_idx  <= '0;
        end else if (word_full) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= word_idx;
            wr_data_q <= pack_set;
            word_idx  <= word_idx + ADDR_W'(1);
        end else if (state == S_FLUSH) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= word_idx;
            wr_data_q <= pack;
            word_idx  <= word_idx + ADDR_W'(1);
        end else begin
            wr_en_q   <= 1'b0;
        end
    end

    // Sticky status: overflow on discarded pixels, done one cycle into DONE
    // so it follows the final write strobe
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.clear) begin
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (last_pix && surplus) begin
                overflow_q <= 1'b1;
            end
            if (state == S_DONE) begin
                done_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready = alive && (state == S_IDLE);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign fsm_state    = state;

endmodule

// File: tb/tb_image_rle_decompressor.sv
// Bench for image_rle_decompressor: directed scenarios plus randomized
// images checked against a pixel-list reference model.
module tb_image_rle_decompressor;

    localparam int N_A = 784;
    localparam int N_B = 20;
    localparam int AW  = 6;
    localparam int W   = AW + 16;

    logic clk = 1'b0;
    logic RST;
    logic [2:0] a_state;
    logic [2:0] b_state;

    // Clock
    always #5 clk = ~clk;

    image_rle_decompressor_if #(.ADDR_W(AW)) a_if ();
    image_rle_decompressor_if #(.ADDR_W(AW)) b_if ();

    image_rle_decompressor #(.NUM_PIXELS(N_A), .ADDR_W(AW)) dut_a (
        .clk(clk), .RST(RST), .bus(a_if), .fsm_state(a_state)
    );
    image_rle_decompressor #(.NUM_PIXELS(N_B), .ADDR_W(AW)) dut_b (
        .clk(clk), .RST(RST), .bus(b_if), .fsm_state(b_state)
    );

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_a[$];
    logic [W-1:0] got_b[$];
    logic [15:0]  m_words[$];
    int           m_acc;
    bit           m_done;
    bit           m_ovf;
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_fail   = 0;

    // Write monitors
    always @(negedge clk) begin
        if (a_if.wr_en) got_a.push_back({a_if.wr_addr, a_if.wr_data});
        if (b_if.wr_en) got_b.push_back({b_if.wr_addr, b_if.wr_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expand codes to a pixel list, cut at n, pack 16 per word
    task automatic model_run(input int n);
        bit pix[$];
        logic [7:0]  code;
        logic [15:0] word;
        int nwords;
        pix = {};
        m_ovf = 0;
        m_acc = 0;
        exp_q.delete();
        for (int i = 0; i < m_words.size(); i++) begin
            if (pix.size() >= n) break;
            m_acc++;
            for (int c = 0; c < 2; c++) begin
                code = (c == 0) ? m_words[i][15:8] : m_words[i][7:0];
                for (int k = 0; k < int'(code[6:0]); k++) begin
                    if (pix.size() < n) pix.push_back(code[7]);
                    else m_ovf = 1;
                end
            end
        end
        m_done = (pix.size() == n);
        nwords = m_done ? (n + 15) / 16 : pix.size() / 16;
        for (int wi = 0; wi < nwords; wi++) begin
            word = 16'd0;
            for (int b = 0; b < 16; b++)
                if (wi * 16 + b < pix.size()) word[b] = pix[wi * 16 + b];
            exp_q.push_back({AW'(wi), word});
        end
    endtask

    function automatic logic [7:0] rnd_code();
        logic [6:0] len;
        len = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
        return {1'($urandom_range(0, 1)), len};
    endfunction

    // Driver: offer one word from a negedge; ok when it was taken
    task automatic send(input bit sel, input logic [15:0] w, input int max_wait, output bit ok);
        ok = 0;
        if (sel) begin b_if.Din = w; b_if.in_valid = 1'b1; end
        else     begin a_if.Din = w; a_if.in_valid = 1'b1; end
        for (int i = 0; i < max_wait && !ok; i++) begin
            if (sel ? b_if.in_ready : a_if.in_ready) ok = 1;
            @(negedge clk);
        end
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
    endtask

    task automatic pulse_clear(input bit sel);
        if (sel) b_if.clear = 1'b1; else a_if.clear = 1'b1;
        @(negedge clk);
        a_if.clear = 1'b0;
        b_if.clear = 1'b0;
    endtask

    // Run m_words as one image and compare writes and flags with the model
    task automatic run_image(input string tag, input bit sel, input int n);
        int acc;
        bit ok;
        logic [W-1:0] g[$];
        acc = 0;
        pulse_clear(sel);
        if (sel) got_b.delete(); else got_a.delete();
        for (int i = 0; i < m_words.size(); i++) begin
            send(sel, m_words[i], 300, ok);
            if (ok) acc++;
        end
        repeat (300) @(negedge clk);
        model_run(n);
        g = sel ? got_b : got_a;
        check({tag, "_accepted"}, acc, m_acc);
        check({tag, "_nwrites"}, g.size(), exp_q.size());
        for (int i = 0; i < g.size() && i < exp_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), g[i], exp_q[i]);
        check({tag, "_done"}, sel ? b_if.done : a_if.done, m_done);
        check({tag, "_overflow"}, sel ? b_if.overflow : a_if.overflow, m_ovf);
    endtask

    // Directed and randomized sequence
    initial begin
        bit ok;
        int lat;
        a_if.clear = 0; a_if.in_valid = 0; a_if.Din = '0;
        b_if.clear = 0; b_if.in_valid = 0; b_if.Din = '0;
        RST = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_in_ready", a_if.in_ready, 0);
        check("rst_wr_en", a_if.wr_en, 0);
        check("rst_wr_addr", a_if.wr_addr, 0);
        check("rst_wr_data", a_if.wr_data, 0);
        check("rst_done", a_if.done, 0);
        check("rst_overflow", a_if.overflow, 0);
        check("rst_b_in_ready", b_if.in_ready, 0);
        RST = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", a_if.in_ready, 1);
        repeat (20) @(negedge clk);
        check("idle_no_writes", got_a.size(), 0);
        check("idle_in_ready", a_if.in_ready, 1);

        // Pack one word
        m_words = {16'h8A05, 16'h8100};
        run_image("pack", 0, N_A);
        check("pack_count", got_a.size(), 1);
        if (got_a.size() > 0) check("pack_word", got_a[0], {AW'(0), 16'h83FF});

        // Zero-length codes and handshake while busy
        pulse_clear(0);
        got_a.delete();
        a_if.Din = 16'h0000; a_if.in_valid = 1'b1;
        check("zl_ready_c0", a_if.in_ready, 1);
        @(negedge clk);
        a_if.Din = 16'h1234;
        check("zl_ready_c1", a_if.in_ready, 0);
        @(negedge clk);
        check("zl_ready_c2", a_if.in_ready, 0);
        @(negedge clk);
        check("zl_ready_c3", a_if.in_ready, 1);
        a_if.in_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("zl_no_writes", got_a.size(), 0);
        check("zl_still_idle", a_if.in_ready, 1);

        // clear beats in_valid in the same cycle
        a_if.Din = 16'h9000; a_if.in_valid = 1'b1; a_if.clear = 1'b1;
        @(negedge clk);
        a_if.in_valid = 1'b0; a_if.clear = 1'b0;
        check("clr_prio_ready", a_if.in_ready, 1);

        // Randomized full images
        for (int r = 0; r < 4; r++) begin
            m_words = {};
            for (int i = 0; i < 14; i++) m_words.push_back({rnd_code(), rnd_code()});
            run_image($sformatf("rnd%0d", r), 0, N_A);
        end
        // Randomized partial image (at most 762 pixels)
        m_words = {};
        for (int i = 0; i < 3; i++) m_words.push_back({rnd_code(), rnd_code()});
        run_image("rnd_part", 0, N_A);

        // Full image with oversupply
        m_words = {};
        for (int i = 0; i < 49; i++) m_words.push_back(16'hFF91);
        run_image("full", 0, N_A);
        check("full_count", got_a.size(), 49);
        for (int i = 0; i < got_a.size() && i < 49; i++)
            check($sformatf("full_const%0d", i), got_a[i], {AW'(i), 16'hFFFF});
        check("full_done", a_if.done, 1);
        check("full_overflow", a_if.overflow, 1);
        check("full_ready_low", a_if.in_ready, 0);

        // Mid-run restart
        pulse_clear(0);
        got_a.delete();
        send(0, 16'h8A05, 10, ok);
        check("mid_accept", ok, 1);
        repeat (3) @(negedge clk);
        pulse_clear(0);
        repeat (30) @(negedge clk);
        check("mid_no_write", got_a.size(), 0);
        send(0, 16'h9000, 10, ok);
        check("mid_accept2", ok, 1);
        lat = 1;
        while (!a_if.wr_en && lat < 40) begin @(negedge clk); lat++; end
        check("mid_wr_latency", lat, 17);
        repeat (20) @(negedge clk);
        check("mid_count", got_a.size(), 1);
        if (got_a.size() > 0) check("mid_word", got_a[0], {AW'(0), 16'hFFFF});
        check("mid_done", a_if.done, 0);
        check("mid_overflow", a_if.overflow, 0);

        // Small image: flush and overflow
        m_words = {16'hFF00};
        run_image("flush", 1, N_B);
        check("flush_count", got_b.size(), 2);
        if (got_b.size() > 1) begin
            check("flush_w0", got_b[0], {AW'(0), 16'hFFFF});
            check("flush_w1", got_b[1], {AW'(1), 16'h000F});
        end

        // Flush latency and done following the last write
        pulse_clear(1);
        send(1, 16'hFF00, 10, ok);
        check("fl_accept", ok, 1);
        lat = 1;
        while (!(b_if.wr_en && b_if.wr_addr == AW'(1)) && lat < 60) begin @(negedge clk); lat++; end
        check("fl_latency", lat, 22);
        check("fl_done_with_wr", b_if.done, 0);
        @(negedge clk);
        check("fl_done_after", b_if.done, 1);

        // Randomized small images
        for (int r = 0; r < 3; r++) begin
            m_words = {};
            for (int i = 0; i < 3; i++) m_words.push_back({1'($urandom_range(0, 1)), 7'($urandom_range(0, 12)),
                                                          1'($urandom_range(0, 1)), 7'($urandom_range(0, 12))});
            run_image($sformatf("rndb%0d", r), 1, N_B);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
